// File: rtl/mem_access_responder_pkg.sv
// Shared types for the memory access responder: entry widths, queue entry layout, FSM states.
// Widths alias the core's physical-address, memory-entry and memory-serial datapaths.
package MemAccessResponderTypes;

    localparam int PHY_ADDR_WIDTH          = 32;
    localparam int MEMORY_ENTRY_WIDTH      = 128;
    localparam int MEM_ACCESS_SERIAL_WIDTH = 4;
    localparam int MEM_REQ_QUEUE_DEPTH     = 4;

    typedef logic [PHY_ADDR_WIDTH-1:0]          phy_addr_t;
    typedef logic [MEMORY_ENTRY_WIDTH-1:0]      mem_entry_t;
    typedef logic [MEM_ACCESS_SERIAL_WIDTH-1:0] mem_serial_t;

    typedef struct packed {
        logic        is_write;
        phy_addr_t   addr;
        mem_entry_t  data;
        mem_serial_t serial;
    } mem_req_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_READ = 2'd2,
        ST_RESPOND   = 2'd3
    } resp_state_t;

endpackage

// File: rtl/mem_access_responder_queue.sv
// In-order request FIFO with wrap-around pointers; head visible combinationally, one-cycle push-to-head.
// Pushes while full and pops while empty are ignored; simultaneous push and pop keep the count.
module mem_request_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/mem_access_responder.sv
// Accepts core line requests, queues them in order, and runs them one at a time on a req/grant RAM port.
// Read latency >= 4 cycles accept-to-pulse; busy (queue full) drops new requests and flags protocolError.
module mem_access_responder
    import MemAccessResponderTypes::*;
#(
    parameter int ADDR_WIDTH   = PHY_ADDR_WIDTH,
    parameter int LINE_WIDTH   = MEMORY_ENTRY_WIDTH,
    parameter int SERIAL_WIDTH = MEM_ACCESS_SERIAL_WIDTH,
    parameter int QUEUE_DEPTH  = MEM_REQ_QUEUE_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   memAccessAddr,
    input  logic [LINE_WIDTH-1:0]   memAccessWriteData,
    input  logic                    memAccessRE,
    input  logic                    memAccessWE,
    output logic                    memAccessReadBusy,
    output logic                    memAccessWriteBusy,
    output logic [SERIAL_WIDTH-1:0] nextMemReadSerial,
    output logic [SERIAL_WIDTH-1:0] nextMemWriteSerial,
    output logic [LINE_WIDTH-1:0]   memReadData,
    output logic                    memReadDataReady,
    output logic [SERIAL_WIDTH-1:0] memReadSerial,
    output logic                    memAccessResponseValid,
    output logic [SERIAL_WIDTH-1:0] memAccessResponseSerial,
    output logic                    ramReq,
    output logic                    ramWE,
    output logic [ADDR_WIDTH-1:0]   ramAddr,
    output logic [LINE_WIDTH-1:0]   ramWData,
    input  logic                    ramGrant,
    input  logic                    ramRValid,
    input  logic [LINE_WIDTH-1:0]   ramRData,
    output logic                    protocolError
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    mem_req_entry_t          enq_entry;
    mem_req_entry_t          head_entry;
    mem_req_entry_t          iss_q;
    resp_state_t             state_q;
    resp_state_t             state_d;
    logic [SERIAL_WIDTH-1:0] rd_serial_q;
    logic [SERIAL_WIDTH-1:0] wr_serial_q;
    logic [LINE_WIDTH-1:0]   rdata_q;
    logic                    proto_err_q;
    logic [CNT_W-1:0]        q_count;
    logic                    q_full;
    logic                    q_empty;
    logic                    q_pop;
    logic                    busy;
    logic                    wr_accept;
    logic                    rd_accept;
    logic                    proto_set;
    logic                    load_iss;
    logic                    cap_rdata;
    logic                    responding;

    assign busy      = (q_count == FULL_CNT);
    assign wr_accept = memAccessWE & ~busy;
    assign rd_accept = memAccessRE & ~memAccessWE & ~busy;

    // Dual request, request-while-busy and stray read data are all sticky violations.
    assign proto_set = (memAccessRE & memAccessWE)
                     | ((memAccessRE | memAccessWE) & busy)
                     | (ramRValid & (state_q != ST_WAIT_READ));

    always_comb begin
        enq_entry          = '0;
        enq_entry.is_write = memAccessWE;
        enq_entry.addr     = memAccessAddr;
        enq_entry.data     = memAccessWriteData;
        enq_entry.serial   = memAccessWE ? wr_serial_q : rd_serial_q;
    end

    mem_request_queue #(
        .WIDTH ($bits(mem_req_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_accept | rd_accept),
        .push_dat (enq_entry),
        .pop      (q_pop),
        .head_dat (head_entry),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    always_comb begin
        state_d   = state_q;
        q_pop     = 1'b0;
        load_iss  = 1'b0;
        cap_rdata = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    load_iss = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The head stays queued (and counts toward busy) until the RAM takes it.
                if (ramGrant) begin
                    q_pop   = 1'b1;
                    state_d = iss_q.is_write ? ST_RESPOND : ST_WAIT_READ;
                end
            end
            ST_WAIT_READ: begin
                if (ramRValid) begin
                    cap_rdata = 1'b1;
                    state_d   = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            iss_q       <= '0;
            rdata_q     <= '0;
            rd_serial_q <= '0;
            wr_serial_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_iss)  iss_q       <= head_entry;
            if (cap_rdata) rdata_q     <= ramRData;
            if (rd_accept) rd_serial_q <= rd_serial_q + 1'b1;
            if (wr_accept) wr_serial_q <= wr_serial_q + 1'b1;
            if (proto_set) proto_err_q <= 1'b1;
        end
    end

    assign responding = (state_q == ST_RESPOND);

    assign memAccessReadBusy       = busy;
    assign memAccessWriteBusy      = q_full;
    assign nextMemReadSerial       = rd_serial_q;
    assign nextMemWriteSerial      = wr_serial_q;
    assign memReadData             = rdata_q;
    assign memReadDataReady        = responding & ~iss_q.is_write;
    assign memReadSerial           = memReadDataReady ? iss_q.serial : '0;
    assign memAccessResponseValid  = responding & iss_q.is_write;
    assign memAccessResponseSerial = memAccessResponseValid ? iss_q.serial : '0;
    assign ramReq                  = (state_q == ST_ISSUE);
    assign ramWE                   = iss_q.is_write;
    assign ramAddr                 = iss_q.addr;
    assign ramWData                = iss_q.data;
    assign protocolError           = proto_err_q;

endmodule
